pipe_skid_reg: RTL and testbench

- Elastic valid/ready pipeline register placed between two RV pipeline stages, e.g. IF→ID or ID→EX. It is built from the same N-bit register primitives the core already uses.
- Two-entry skid buffer: one main register plus one skid register.
- Supports full throughput while registering the ready path, so there is no combinational path from out_ready to in_ready.
- Synchronous flush supports branch/jump squash.

---
 rtl/pipe_skid_reg_if.sv | 29 ++
 rtl/pipe_skid_reg.sv | 106 ++++++++++
 tb/tb_pipe_skid_reg.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: valid/ready handshake bundle around one pipeline register.
//
// Signals:
//   in_valid  / in_ready  / in_data   upstream side (producer -> register)
//   out_valid / out_ready / out_data  downstream side (register -> consumer)
//
// Modports:
//   master : the environment (drives in_*, out_ready; observes the rest)
//   slave  : the pipeline register itself
interface pipe_skid_reg_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry elastic pipeline register (main + skid).
//
// Sits between two pipeline stages. Full throughput is sustained while
// in_ready comes straight from a flop, so out_ready never reaches in_ready
// through logic in the same cycle. flush squashes everything buffered.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (clears state and data)
//   flush      synchronous squash of all buffered entries
//   bus        pipe_skid_reg_if.slave handshake bundle
//   state_dbg  current FSM state: 0=EMPTY, 1=BUSY, 2=FULL
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on the same side (in_fire = in_valid & in_ready, out_fire =
// out_valid & out_ready). A producer holding valid=1 keeps its data stable
// until the transfer; out_valid/out_data are held while out_ready=0.
module pipe_skid_reg #(
   parameter int N = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   pipe_skid_reg_if.slave      bus,
   output logic [1:0]          state_dbg
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,   // main invalid
      BUSY  = 2'b01,   // main valid, skid invalid
      FULL  = 2'b10    // main and skid valid; skid is the younger entry
   } state_t;

   state_t       state;
   logic [N-1:0] main_q;
   logic [N-1:0] skid_q;
   logic         out_valid_q;
   logic         in_ready_q;
   logic         in_fire;
   logic         out_fire;

   assign in_fire  = bus.in_valid & in_ready_q;
   assign out_fire = out_valid_q & bus.out_ready;

   // out_valid_q / in_ready_q are kept equal to (state != EMPTY) and
   // (state != FULL) by updating them alongside every state change, so both
   // outputs leave the block straight from flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else if (flush) begin
         // Data registers are left alone; out_data is meaningless while
         // out_valid=0. A same-cycle out_fire has already been consumed.
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  main_q      <= bus.in_data;
                  state       <= BUSY;
                  out_valid_q <= 1'b1;
                  in_ready_q  <= 1'b1;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  main_q <= bus.in_data;
               end else if (in_fire) begin
                  // Downstream stalled: park the new beat behind main.
                  skid_q     <= bus.in_data;
                  state      <= FULL;
                  in_ready_q <= 1'b0;
               end else if (out_fire) begin
                  state       <= EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            FULL: begin
               // in_ready is 0 here, so only the drain side can move.
               if (out_fire) begin
                  main_q     <= skid_q;
                  state      <= BUSY;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state       <= EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_data  = main_q;
   assign state_dbg     = state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: self-checking bench for pipe_skid_reg.
//
// The reference model is a queue of at most two buffered beats: the head is
// what the output must show, in_ready is "fewer than two held", and a flush
// or reset empties it.
module tb_pipe_skid_reg;

   localparam int N = 32;

   logic       clk;
   logic       rst;
   logic       flush;
   logic [1:0] state_dbg;

   pipe_skid_reg_if #(.N(N)) bus ();

   pipe_skid_reg #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard / model ----------------
   logic [N-1:0] exp_q[$];
   int           total = 0;
   int           bad   = 0;
   logic         seen_squashed = 1'b0;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Check outputs against the model, probe that in_ready does not follow
   // out_ready, advance one clock, then update the model. Returns 1 time
   // unit after the rising edge.
   task automatic cycle();
      int   sz;
      logic ir0;
      logic m_in_fire;
      logic m_out_fire;
      sz = exp_q.size();
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, (sz != 0)});
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, (sz < 2)});
      chk("state", {30'b0, state_dbg}, sz[N-1:0]);
      if (sz != 0) chk("out_data", bus.out_data, exp_q[0]);
      if (bus.out_valid && bus.out_data == 32'h33333333) seen_squashed = 1'b1;
      ir0 = bus.in_ready;
      bus.out_ready = ~bus.out_ready;
      #1;
      chk("in_ready_no_comb", {31'b0, bus.in_ready}, {31'b0, ir0});
      bus.out_ready = ~bus.out_ready;
      m_in_fire  = rst && bus.in_valid && (sz < 2);
      m_out_fire = rst && (sz != 0) && bus.out_ready;
      @(posedge clk);
      if (!rst || flush) begin
         exp_q.delete();
      end else begin
         if (m_out_fire) void'(exp_q.pop_front());
         if (m_in_fire) exp_q.push_back(bus.in_data);
      end
      #1;
   endtask

   task automatic drive(input logic iv, input logic [N-1:0] d, input logic ordy, input logic fl);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      flush         = fl;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic         iv;
      logic [N-1:0] d;
      logic         ordy;
      logic         fl;
      logic         ov;      // expected after the edge
      logic         ir;
      logic [N-1:0] od;
      logic         chk_d;
      logic [1:0]   st;
   } vec_t;

   vec_t vecs[13];

   initial begin
      // backpressure fill and ordered drain
      vecs[0]  = '{1'b1, 32'hdeadbeef, 1'b0, 1'b0, 1'b1, 1'b1, 32'hdeadbeef, 1'b1, 2'd1};
      vecs[1]  = '{1'b1, 32'hcafebabe, 1'b0, 1'b0, 1'b1, 1'b0, 32'hdeadbeef, 1'b1, 2'd2};
      vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hdeadbeef, 1'b1, 2'd2};
      vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'hcafebabe, 1'b1, 2'd1};
      vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 2'd0};
      // simultaneous in/out while BUSY
      vecs[5]  = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11111111, 1'b1, 2'd1};
      vecs[6]  = '{1'b1, 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22222222, 1'b1, 2'd1};
      // fill, then flush while FULL with in_valid high
      vecs[7]  = '{1'b1, 32'h44444444, 1'b0, 1'b0, 1'b1, 1'b0, 32'h22222222, 1'b1, 2'd2};
      vecs[8]  = '{1'b1, 32'h33333333, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 2'd0};
      vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 2'd0};
      // flush in BUSY with a real in_fire and out_fire in the same cycle
      vecs[10] = '{1'b1, 32'h55555555, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55555555, 1'b1, 2'd1};
      vecs[11] = '{1'b1, 32'h33333333, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 2'd0};
      vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 2'd0};
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [N-1:0] d;
      rst = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);

      // 1. reset held for two edges, then released
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("rst_out_data", bus.out_data, 32'd0);
      rst = 1'b1;
      #1;
      chk("rel_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("rel_out_data", bus.out_data, 32'd0);

      // stream 1..8 at full rate: each value appears one cycle after in_fire
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, i, 1'b1, 1'b0);
         cycle();
         chk("stream_valid", {31'b0, bus.out_valid}, 32'd1);
         chk("stream_data", bus.out_data, i);
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      cycle();
      chk("stream_drained", {31'b0, bus.out_valid}, 32'd0);

      // 2-4. directed vector table
      for (int v = 0; v < 13; v++) begin
         drive(vecs[v].iv, vecs[v].d, vecs[v].ordy, vecs[v].fl);
         cycle();
         chk($sformatf("vec%0d_out_valid", v), {31'b0, bus.out_valid}, {31'b0, vecs[v].ov});
         chk($sformatf("vec%0d_in_ready", v), {31'b0, bus.in_ready}, {31'b0, vecs[v].ir});
         chk($sformatf("vec%0d_state", v), {30'b0, state_dbg}, {30'b0, vecs[v].st});
         if (vecs[v].chk_d) chk($sformatf("vec%0d_out_data", v), bus.out_data, vecs[v].od);
      end

      // 3. random stalls with a rare flush, checked against the model
      for (int k = 0; k < 300; k++) begin
         d = $urandom;
         if (d == 32'h33333333) d = 32'h0;
         drive($urandom_range(0, 1) == 1, d, $urandom_range(0, 2) != 0,
               (k >= 100) && ($urandom_range(0, 24) == 0));
         cycle();
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      repeat (3) cycle();
      chk("random_drained", exp_q.size(), 32'd0);

      // 6. stall stability while BUSY
      drive(1'b1, 32'h66666666, 1'b0, 1'b0);
      cycle();
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int s = 0; s < 10; s++) begin
         cycle();
         chk("stall_data", bus.out_data, 32'h66666666);
         chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
         chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd1);
      end
      drive(1'b1, 32'h77777777, 1'b0, 1'b0);
      cycle();
      chk("stall_full_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("stall_full_state", {30'b0, state_dbg}, 32'd2);

      // 5. asynchronous reset between edges while FULL
      drive(1'b0, '0, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("arst_out_data", bus.out_data, 32'd0);
      chk("arst_state", {30'b0, state_dbg}, 32'd0);
      exp_q.delete();
      cycle();
      rst = 1'b1;
      drive(1'b1, 32'h88888888, 1'b1, 1'b0);
      cycle();
      chk("post_arst_data", bus.out_data, 32'h88888888);
      drive(1'b0, '0, 1'b1, 1'b0);
      repeat (2) cycle();

      chk("squashed_never_seen", {31'b0, seen_squashed}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
